// File: rtl/vec_buffer_responder.sv
// Responder end of the vector tile interface: NUM_BUFFERS tile buffers, each
// streamed through its own read and write pointer, behind one registered read stage.
module vec_buffer_responder #(
    parameter int DATA_WIDTH  = 8,
    parameter int TILE_ELEMS  = 32,
    parameter int TILE_DEPTH  = 32,
    parameter int NUM_BUFFERS = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  vec_read_enable,
    input  logic [4:0]                            vec_read_buffer_id,
    output logic [TILE_ELEMS-1:0][DATA_WIDTH-1:0] vec_read_tile,
    output logic                                  vec_read_valid,
    input  logic                                  vec_write_enable,
    input  logic [4:0]                            vec_write_buffer_id,
    input  logic [TILE_ELEMS-1:0][DATA_WIDTH-1:0] vec_write_tile,
    input  logic                                  ptr_clear,
    input  logic [4:0]                            ptr_clear_buffer_id,
    output logic                                  err_bad_id
);

    localparam int ID_W  = 5;
    localparam int BUF_W = (NUM_BUFFERS > 1) ? $clog2(NUM_BUFFERS) : 1;
    localparam int PTR_W = (TILE_DEPTH > 1) ? $clog2(TILE_DEPTH) : 1;

    typedef logic [TILE_ELEMS-1:0][DATA_WIDTH-1:0] tile_t;
    typedef logic [PTR_W-1:0]                      ptr_t;
    typedef logic [BUF_W-1:0]                      buf_t;

    localparam ptr_t LAST_TILE = ptr_t'(TILE_DEPTH - 1);

    function automatic logic id_valid(input logic [ID_W-1:0] id);
        return int'(id) < NUM_BUFFERS;
    endfunction

    function automatic ptr_t ptr_next(input ptr_t p);
        return (p == LAST_TILE) ? '0 : p + ptr_t'(1);
    endfunction

    tile_t mem    [NUM_BUFFERS][TILE_DEPTH];
    ptr_t  rd_ptr [NUM_BUFFERS];
    ptr_t  wr_ptr [NUM_BUFFERS];

    logic rd_ok;
    logic wr_ok;
    logic clr_ok;
    logic any_bad;
    buf_t rd_buf;
    buf_t wr_buf;
    buf_t clr_buf;
    ptr_t rd_row;
    ptr_t wr_row;

    assign rd_ok   = vec_read_enable  && id_valid(vec_read_buffer_id);
    assign wr_ok   = vec_write_enable && id_valid(vec_write_buffer_id);
    assign clr_ok  = ptr_clear        && id_valid(ptr_clear_buffer_id);
    assign any_bad = (vec_read_enable  && !id_valid(vec_read_buffer_id))  ||
                     (vec_write_enable && !id_valid(vec_write_buffer_id)) ||
                     (ptr_clear        && !id_valid(ptr_clear_buffer_id));

    assign rd_buf  = vec_read_buffer_id[BUF_W-1:0];
    assign wr_buf  = vec_write_buffer_id[BUF_W-1:0];
    assign clr_buf = ptr_clear_buffer_id[BUF_W-1:0];

    // A clear aimed at the accessed buffer takes effect first, so the access uses tile 0.
    always_comb begin
        // NOTE: every output gets a default before any condition, otherwise a latch is inferred.
        rd_row = rd_ptr[rd_buf];
        wr_row = wr_ptr[wr_buf];
        if (clr_ok && clr_buf == rd_buf) begin
            rd_row = '0;
        end
        if (clr_ok && clr_buf == wr_buf) begin
            wr_row = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BUFFERS; b++) begin
                rd_ptr[b] <= '0;
                wr_ptr[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NUM_BUFFERS; b++) begin
                if (rd_ok && rd_buf == buf_t'(b)) begin
                    rd_ptr[b] <= ptr_next(rd_row);
                end else if (clr_ok && clr_buf == buf_t'(b)) begin
                    rd_ptr[b] <= '0;
                end
                if (wr_ok && wr_buf == buf_t'(b)) begin
                    wr_ptr[b] <= ptr_next(wr_row);
                end else if (clr_ok && clr_buf == buf_t'(b)) begin
                    wr_ptr[b] <= '0;
                end
            end
        end
    end

    // NOTE: storage has no reset; clearing a RAM array costs a reset net per bit and its contents are undefined anyway.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_buf][wr_row] <= vec_write_tile;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_read_valid <= 1'b0;
            vec_read_tile  <= '0;
        end else begin
            // NOTE: non-blocking assignment, so this samples mem before the same-edge write lands.
            vec_read_valid <= vec_read_enable;
            if (vec_read_enable) begin
                vec_read_tile <= rd_ok ? mem[rd_buf][rd_row] : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_bad_id <= 1'b0;
        end else if (any_bad) begin
            err_bad_id <= 1'b1;
        end
    end

endmodule

// File: doc/vec_buffer_responder.md
Name: vec_buffer_responder

Overview:
- Responder end of the execution-unit vector tile interface: serves `vec_read_enable` requests with `vec_read_tile`/`vec_read_valid` and absorbs `vec_write_enable` tile writes.
- Holds NUM_BUFFERS independent vector buffers, each TILE_DEPTH tiles of TILE_ELEMS signed elements.
- Keeps a sequential read pointer and write pointer per buffer, so initiators stream tiles without addressing.
- Sits between the execution modules (ReLU, GEMV, load/store) and the buffer storage.

Parameters:
DATA_WIDTH, 8, element width in bits (signed)
TILE_ELEMS, 32, elements per tile
TILE_DEPTH, 32, tiles per buffer (1024 elements at defaults)
NUM_BUFFERS, 4, implemented buffer ids 0..NUM_BUFFERS-1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
vec_read_enable  in  1  one-cycle read request pulse
vec_read_buffer_id  in  5  buffer to read
vec_read_tile  out  TILE_ELEMS x DATA_WIDTH signed  read data, registered
vec_read_valid  out  1  one-cycle pulse, tile valid
vec_write_enable  in  1  one-cycle write pulse
vec_write_buffer_id  in  5  buffer to write
vec_write_tile  in  TILE_ELEMS x DATA_WIDTH signed  write data
ptr_clear  in  1  rewind both pointers of one buffer to tile 0
ptr_clear_buffer_id  in  5  buffer to rewind
err_bad_id  out  1  sticky: access to an id >= NUM_BUFFERS

Behaviour:
- Reset (rst_n low, asynchronous):
  - `vec_read_valid`=0, `vec_read_tile` all 0, `err_bad_id`=0.
  - All read and write pointers are 0.
  - Storage contents are not reset and are undefined until written.
- Reset mid-operation: a read issued in the cycle before reset asserts produces no `vec_read_valid`. After release, the block accepts requests on the first clk edge.
- Read:
  - `vec_read_enable` sampled high at edge N with id b → edge N+1: `vec_read_tile` = buffer b tile rd_ptr[b], `vec_read_valid`=1 for exactly one cycle.
  - rd_ptr[b] then increments.
  - Fixed 1-cycle latency, no backpressure. Back-to-back reads on consecutive cycles give consecutive valid pulses.
- Write:
  - `vec_write_enable` high at edge N stores `vec_write_tile` into buffer b tile wr_ptr[b].
  - wr_ptr[b] then increments.
- Pointer wrap: a pointer at TILE_DEPTH-1 increments to 0. No error is flagged on wrap.
- Pointer independence:
  - rd_ptr and wr_ptr are independent per buffer, and buffers are independent of each other.
  - A simultaneous read and write in one cycle is always accepted.
- Same buffer, same tile, same cycle: the read returns the pre-write data (read-before-write). The write lands at the edge.
- `vec_read_tile` hold: it keeps its last value when `vec_read_valid` is 0. Consumers sample only on valid.
- `ptr_clear` (sampled at edge, id c): rd_ptr[c] and wr_ptr[c] become 0.
- `ptr_clear` in the same cycle as a read or write to buffer c: clear applies first. The access uses tile 0 and the pointer ends at 1.
- `ptr_clear` for any other buffer id does not disturb the in-flight access.
- Bad id (read, write or clear with id >= NUM_BUFFERS):
  - Bad-id read: still returns `vec_read_valid`=1 with an all-zero tile. No pointer changes.
  - Bad-id write: dropped.
  - Bad-id clear: ignored.
  - In all three cases `err_bad_id` is set and stays set until reset.
- No internal FSM beyond per-buffer pointer registers and the registered read stage. The read pipeline is 1 stage and is never stalled.

Test Plan:
- Reset with `rst_n`=0 → `vec_read_valid`=0, `vec_read_tile` all 0, `err_bad_id`=0. After release, write buffer 1 with tile elements i-16 (i=0..31), clear buffer 1, then read → next cycle valid=1 and tile[0]=-16, tile[31]=15.
- Streaming: write 3 tiles (values 1, 2, 3 in every element) to buffer 0, clear, then issue 3 reads on consecutive cycles → three consecutive valid pulses returning 1, 2, 3. No valid on the 4th cycle.
- In-place traffic:
  - Setup: buffer 2 tile 0 = -5, clear.
  - Same cycle: read buffer 2, write buffer 2 with 7.
  - Required: read returns -5; a later clear+read returns 7.
  - Separately: read buffer 0 while writing buffer 3 in one cycle → both accepted.
- Wrap: perform TILE_DEPTH+1 = 33 writes to buffer 3, the last with value 9, then clear rd only (the clear also zeroes wr), and read → tile 0 = 9.
- Clear collision: with buffer 1 rd_ptr=5, assert `ptr_clear`(1) and a read of buffer 1 in the same cycle → data returned from tile 0, next read returns tile 1.
- Bad id: read id 7 → valid=1, all-zero tile, `err_bad_id`=1. A write to id 4 leaves buffers 0..3 unchanged. `err_bad_id` stays 1 until `rst_n` pulses low.
